sqrt_settle_capture: RTL and testbench

Consumes the IEEE-754 single-precision iteration stream produced by the square-root op-amp loop, one sample per clk_100k edge. After a start pulse it detects when the stream has settled, or gives up at a timeout. It then converts the settled value to unsigned fixed point (integer + fraction) and holds it on a valid/ready handshake for display/readout logic.

---
 rtl/sqrt_capture_pkg.sv | 34 +++
 rtl/sqrt_settle_capture_ieee_to_fixed.sv | 102 ++++++++++
 rtl/sqrt_settle_capture.sv | 166 ++++++++++++++++
 tb/tb_sqrt_settle_capture.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_capture_pkg.sv
// Shared types and IEEE-754 single-precision field constants for the
// square-root settle/capture block.
// Optional build macro: RESULT_ROUND_EN (round-half-up in ieee_to_fixed).
package sqrt_capture_pkg;

  // Capture controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_CONVERT = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // IEEE-754 single-precision field layout
  localparam int EXP_BIAS = 127;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;
  localparam int SIGN_BIT = 31;

  // Biased exponent reserved for Inf/NaN
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  // Biased exponent field of a single-precision word
  function automatic logic [7:0] ieee_exp(input logic [31:0] v);
    return v[EXP_MSB:EXP_LSB];
  endfunction

  // Significand with the hidden leading one restored
  function automatic logic [MAN_W:0] ieee_mant(input logic [31:0] v);
    return {1'b1, v[MAN_W-1:0]};
  endfunction

endpackage

// File: rtl/sqrt_settle_capture_ieee_to_fixed.sv
// Combinational IEEE-754 single -> unsigned fixed point (INT_W.FRAC_W).
// Negative inputs clamp to zero, zero/denormal exponents give zero, and
// Inf/NaN or values at or above 2^INT_W saturate to all ones.
// Optional build macro: RESULT_ROUND_EN -- when defined, rounds half-up on
// the first discarded bit; a carry out of the integer field saturates.
// When undefined the result is truncated toward zero.
module ieee_to_fixed
  import sqrt_capture_pkg::*;
#(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic [31:0]       ieee,
  output logic [INT_W-1:0]  fix_int,
  output logic [FRAC_W-1:0] fix_frac,
  output logic              overflow,
  output logic              neg_clamp
);

  localparam int OUT_W   = INT_W + FRAC_W;
  // Room for the whole significand shifted to the top of the output field
  localparam int WIDE_W  = OUT_W + MAN_W + 2;
  localparam int SHIFT_W = 11;
  // Shift that places the significand LSB on the fixed-point grid:
  // e - bias - MAN_W + FRAC_W, folded into a single offset
  localparam logic signed [SHIFT_W-1:0] SHIFT_OFS = SHIFT_W'(EXP_BIAS + MAN_W - FRAC_W);
  // Smallest biased exponent whose value no longer fits in INT_W bits
  localparam logic [8:0] EXP_SAT = 9'(EXP_BIAS + INT_W);

  logic [7:0]                exp_f;
  logic [WIDE_W-1:0]         mant_ext;
  logic signed [SHIFT_W-1:0] shift_s;
  logic                      shift_left;
  logic [SHIFT_W-1:0]        shift_mag;
  logic [WIDE_W-1:0]         shifted;
  logic                      wide_ovf;
  logic [OUT_W:0]            rounded;
  logic                      carry_out;

  // Align the significand onto the fixed-point grid
  always_comb begin
    exp_f      = ieee_exp(ieee);
    mant_ext   = WIDE_W'(ieee_mant(ieee));
    shift_s    = $signed({3'b000, exp_f}) - SHIFT_OFS;
    shift_left = ~shift_s[SHIFT_W-1];
    shifted    = '0;
    shift_mag  = '0;
    if (shift_left) begin
      shift_mag = SHIFT_W'(shift_s);
      shifted   = mant_ext << shift_mag;
    end else begin
      shift_mag = SHIFT_W'(-shift_s);
      shifted   = mant_ext >> shift_mag;
    end
  end

  // Any bit above the output field means the value cannot be represented
  assign wide_ovf = |shifted[WIDE_W-1:OUT_W];

`ifdef RESULT_ROUND_EN
  logic [WIDE_W-1:0] round_mask;
  logic              round_bit;

  // First discarded bit sits one position above the shifted-out amount
  always_comb begin
    round_mask = '0;
    round_bit  = 1'b0;
    if (!shift_left) begin
      round_mask = WIDE_W'(1) << (shift_mag - SHIFT_W'(1));
      round_bit  = |(mant_ext & round_mask);
    end
  end

  assign rounded = {1'b0, shifted[OUT_W-1:0]} + {{OUT_W{1'b0}}, round_bit};
`else
  assign rounded = {1'b0, shifted[OUT_W-1:0]};
`endif

  assign carry_out = rounded[OUT_W];

  // Special-case selection: sign clamp beats saturation, zero exponent is zero
  always_comb begin
    fix_int   = '0;
    fix_frac  = '0;
    overflow  = 1'b0;
    neg_clamp = 1'b0;
    if (ieee[SIGN_BIT]) begin
      neg_clamp = 1'b1;
    end else if (exp_f == 8'h00) begin
      fix_int  = '0;
      fix_frac = '0;
    end else if ((exp_f == EXP_ALL_ONES) || ({1'b0, exp_f} >= EXP_SAT) ||
                 wide_ovf || carry_out) begin
      fix_int  = '1;
      fix_frac = '1;
      overflow = 1'b1;
    end else begin
      {fix_int, fix_frac} = rounded[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/sqrt_settle_capture.sv
// Watches the IEEE single iteration stream of the square-root loop, decides
// when it has settled (or gives up after TIMEOUT cycles), converts the
// captured sample to unsigned fixed point and holds it on valid/ready.
// Optional build macro: RESULT_ROUND_EN (round-half-up instead of truncation).
module sqrt_settle_capture
  import sqrt_capture_pkg::*;
#(
  parameter int STABLE_CNT = 8,
  parameter int TIMEOUT    = 1023,
  parameter int CMP_LSB    = 4,
  parameter int INT_W      = 16,
  parameter int FRAC_W     = 8
) (
  input  logic              clk_100k,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       ieee_in,
  output logic [INT_W-1:0]  result_int,
  output logic [FRAC_W-1:0] result_frac,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              timeout,
  output logic              overflow,
  output logic              neg_clamp,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int CMP_W = 32 - CMP_LSB;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CYCLE_LAST  = CNT_W'(TIMEOUT - 1);

  state_t state_reg, state_next;

  // Only the compared bits of the previous sample are worth keeping
  logic [CMP_W-1:0] prev_reg;
  logic [31:0]      cap_reg;
  logic             cap_timeout_reg;
  logic [CNT_W-1:0] stable_cnt_reg;
  logic [CNT_W-1:0] cycle_cnt_reg;

  logic match;
  logic settle_hit;
  logic timeout_hit;

  logic load_track;
  logic track_step;
  logic capture_now;
  logic convert_commit;
  logic handshake_done;

  logic [INT_W-1:0]  conv_int;
  logic [FRAC_W-1:0] conv_frac;
  logic              conv_overflow;
  logic              conv_neg_clamp;

  // Settle/timeout detection on the live sample
  assign match       = (ieee_in[31:CMP_LSB] == prev_reg);
  assign settle_hit  = match && (stable_cnt_reg == STABLE_LAST);
  assign timeout_hit = (cycle_cnt_reg == CYCLE_LAST);

  // State register
  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start restarts tracking from any state
  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_TRACK;
    end else begin
      case (state_reg)
        ST_IDLE:    state_next = ST_IDLE;
        ST_TRACK:   if (settle_hit || timeout_hit) state_next = ST_CONVERT;
        ST_CONVERT: state_next = ST_HOLD;
        ST_HOLD:    if (result_ready) state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Output and datapath strobes decoded from the current state
  always_comb begin
    busy           = (state_reg == ST_TRACK) || (state_reg == ST_CONVERT);
    load_track     = start;
    track_step     = (state_reg == ST_TRACK) && !start;
    capture_now    = track_step && (settle_hit || timeout_hit);
    convert_commit = (state_reg == ST_CONVERT) && !start;
    handshake_done = (state_reg == ST_HOLD) && !start && result_ready;
  end

  // Stream tracking: previous sample and the two counters
  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg       <= '0;
      stable_cnt_reg <= '0;
      cycle_cnt_reg  <= '0;
    end else if (load_track) begin
      prev_reg       <= ieee_in[31:CMP_LSB];
      stable_cnt_reg <= '0;
      cycle_cnt_reg  <= '0;
    end else if (track_step) begin
      prev_reg       <= ieee_in[31:CMP_LSB];
      stable_cnt_reg <= match ? (stable_cnt_reg + CNT_W'(1)) : '0;
      cycle_cnt_reg  <= cycle_cnt_reg + CNT_W'(1);
    end
  end

  // Latch the full sample that ended tracking; settle wins over timeout
  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      cap_reg         <= '0;
      cap_timeout_reg <= 1'b0;
    end else if (capture_now) begin
      cap_reg         <= ieee_in;
      cap_timeout_reg <= !settle_hit;
    end
  end

  ieee_to_fixed #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_conv (
    .ieee      (cap_reg),
    .fix_int   (conv_int),
    .fix_frac  (conv_frac),
    .overflow  (conv_overflow),
    .neg_clamp (conv_neg_clamp)
  );

  // Result registers: loaded in CONVERT, held through HOLD and beyond
  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      result_int  <= '0;
      result_frac <= '0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      neg_clamp   <= 1'b0;
    end else if (convert_commit) begin
      result_int  <= conv_int;
      result_frac <= conv_frac;
      timeout     <= cap_timeout_reg;
      overflow    <= conv_overflow;
      neg_clamp   <= conv_neg_clamp;
    end
  end

  // Valid flag: set by CONVERT, dropped by restart or by the handshake
  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      result_valid <= 1'b0;
    end else if (load_track) begin
      result_valid <= 1'b0;
    end else if (convert_commit) begin
      result_valid <= 1'b1;
    end else if (handshake_done) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sqrt_settle_capture.sv
// Directed, table-driven bench for sqrt_settle_capture (TIMEOUT overridden to 20).
module tb_sqrt_settle_capture;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 8;

  logic              clk_100k = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       ieee_in = '0;
  logic              result_ready = 1'b0;
  logic [INT_W-1:0]  result_int;
  logic [FRAC_W-1:0] result_frac;
  logic              result_valid;
  logic              timeout;
  logic              overflow;
  logic              neg_clamp;
  logic              busy;

  int    n_checks = 0;
  int    n_fail = 0;
  string cur_tag = "init";

  typedef struct {
    logic [31:0] ieee;
    logic [15:0] exp_int;
    logic [7:0]  exp_frac;
    logic        exp_ovf;
    logic        exp_neg;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  sqrt_settle_capture #(
    .STABLE_CNT (8),
    .TIMEOUT    (20),
    .CMP_LSB    (4),
    .INT_W      (INT_W),
    .FRAC_W     (FRAC_W)
  ) dut (
    .clk_100k     (clk_100k),
    .reset_n      (reset_n),
    .start        (start),
    .ieee_in      (ieee_in),
    .result_int   (result_int),
    .result_frac  (result_frac),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .timeout      (timeout),
    .overflow     (overflow),
    .neg_clamp    (neg_clamp),
    .busy         (busy)
  );

  always #5 clk_100k = ~clk_100k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100k);
    #1;
  endtask

  // Pulse start with sample a, then alternate b/a each edge until valid (bounded)
  task automatic run_stream(input logic [31:0] a, input logic [31:0] b, output int lat);
    ieee_in = a;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_after_start", result_valid, 0);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 60) begin
      ieee_in = (lat % 2 == 0) ? b : a;
      tick();
      lat++;
    end
  endtask

  // Accept the held result and confirm return to IDLE
  task automatic ack();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("valid_after_ack", result_valid, 0);
    check("busy_after_ack", busy, 0);
  endtask

  task automatic check_all_zero();
    check("int_zero", result_int, 0);
    check("frac_zero", result_frac, 0);
    check("valid_zero", result_valid, 0);
    check("timeout_zero", timeout, 0);
    check("ovf_zero", overflow, 0);
    check("neg_zero", neg_clamp, 0);
    check("busy_zero", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen_valid;
    logic [INT_W-1:0]  held_int;
    logic [FRAC_W-1:0] held_frac;

    vecs[0]  = '{32'h40C00000, 16'h0006, 8'h00, 1'b0, 1'b0}; // 6.0
    vecs[1]  = '{32'h3FC00000, 16'h0001, 8'h80, 1'b0, 1'b0}; // 1.5
    vecs[2]  = '{32'h40490FDB, 16'h0003, 8'h24, 1'b0, 1'b0}; // pi
    vecs[3]  = '{32'hC0000000, 16'h0000, 8'h00, 1'b0, 1'b1}; // -2.0
    vecs[4]  = '{32'h47800000, 16'hFFFF, 8'hFF, 1'b1, 1'b0}; // 65536
    vecs[5]  = '{32'h7F800000, 16'hFFFF, 8'hFF, 1'b1, 1'b0}; // +Inf
    vecs[6]  = '{32'h00000000, 16'h0000, 8'h00, 1'b0, 1'b0}; // +0
    vecs[7]  = '{32'h3F000000, 16'h0000, 8'h80, 1'b0, 1'b0}; // 0.5
    vecs[8]  = '{32'h477FFF80, 16'hFFFF, 8'h80, 1'b0, 1'b0}; // 65535.5
    vecs[9]  = '{32'hFF800000, 16'h0000, 8'h00, 1'b0, 1'b1}; // -Inf
    vecs[10] = '{32'h7FC00000, 16'hFFFF, 8'hFF, 1'b1, 1'b0}; // NaN
    vecs[11] = '{32'h3B800000, 16'h0000, 8'h01, 1'b0, 1'b0}; // 2^-8

    // Reset state
    cur_tag = "reset";
    tick();
    tick();
    check_all_zero();
    #3 reset_n = 1'b1;
    tick();
    check_all_zero();

    // Constant-input vectors
    for (int i = 0; i < NVEC; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_stream(vecs[i].ieee, vecs[i].ieee, lat);
      $display("vec%0d ieee=%08h lat=%0d int=%04h frac=%02h ovf=%0b neg=%0b tmo=%0b",
               i, vecs[i].ieee, lat, result_int, result_frac, overflow, neg_clamp, timeout);
      check("latency", lat, 9);
      check("int", result_int, vecs[i].exp_int);
      check("frac", result_frac, vecs[i].exp_frac);
      check("overflow", overflow, vecs[i].exp_ovf);
      check("neg_clamp", neg_clamp, vecs[i].exp_neg);
      check("timeout", timeout, 0);
      check("busy_hold", busy, 0);
      ack();
    end

    // Non-settling stream forces capture at the timeout
    cur_tag = "timeout";
    run_stream(32'h40C00000, 32'h40C00100, lat);
    $display("timeout lat=%0d int=%04h frac=%02h tmo=%0b", lat, result_int, result_frac, timeout);
    check("latency", lat, 21);
    check("timeout_flag", timeout, 1);
    check("int", result_int, 16'h0006);
    check("frac", result_frac, 8'h00);
    ack();

    // Differences confined to ignored LSBs still settle
    cur_tag = "lsb_ignore";
    run_stream(32'h40C00000, 32'h40C00003, lat);
    $display("lsb_ignore lat=%0d int=%04h tmo=%0b", lat, result_int, timeout);
    check("latency", lat, 9);
    check("timeout_flag", timeout, 0);
    check("int", result_int, 16'h0006);
    ack();

    // HOLD with backpressure, then restart from HOLD
    cur_tag = "hold";
    run_stream(32'h40C00000, 32'h40C00000, lat);
    check("latency", lat, 9);
    held_int  = result_int;
    held_frac = result_frac;
    ieee_in   = 32'h3FC00000;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("valid_held", result_valid, 1);
      check("int_held", result_int, 16'h0006);
      check("frac_held", result_frac, 8'h00);
    end
    $display("hold int=%04h frac=%02h after 5 stalled cycles", held_int, held_frac);
    cur_tag = "restart";
    run_stream(32'h3FC00000, 32'h3FC00000, lat);
    $display("restart lat=%0d int=%04h frac=%02h", lat, result_int, result_frac);
    check("latency", lat, 9);
    check("int", result_int, 16'h0001);
    check("frac", result_frac, 8'h80);
    ack();

    // Asynchronous reset in the middle of TRACK
    cur_tag = "mid_reset";
    ieee_in = 32'h40C00000;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (4) tick();
    check("busy_before_reset", busy, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero();
    #2 reset_n = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (result_valid === 1'b1 || busy === 1'b1) seen_valid++;
    end
    $display("mid_reset activity_after_release=%0d", seen_valid);
    check("no_activity_after_reset", seen_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
